// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_unit_if
// Brief   : Data-memory port of the MEM-stage load/store unit.
//           The request side (address, enables, write data) is driven by the
//           master. The grant and read-data side is driven by the memory.
// Revision: 1.0 - initial release
// ============================================================================
interface dmem_access_unit_if #(
  parameter int AW = 15
) ();
  logic          DM_REQ;
  logic          DM_WE;
  logic [AW-1:0] DM_ADDR;
  logic [3:0]    DM_BE;
  logic [31:0]   DM_WDATA;
  logic          DM_GNT;
  logic          DM_RVALID;
  logic [31:0]   DM_RDATA;

  modport master (
    output DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA,
    input  DM_GNT, DM_RVALID, DM_RDATA
  );

  modport slave (
    input  DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA,
    output DM_GNT, DM_RVALID, DM_RDATA
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_unit
// Brief   : MEM-stage load/store unit of an RV32I pipeline. Accepts one
//           memory op from EX/MEM, runs it on a req/gnt/rvalid memory port
//           with byte enables and returns the aligned, extended load word.
//           The unit stalls upstream stages while an access is outstanding.
//           Misaligned, out-of-range and timed-out accesses are reported as
//           faults.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE = 32768,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EX_VALID_i,
  input  logic [31:0] EX_ADDR_i,
  input  logic [31:0] EX_WDATA_i,
  input  logic [1:0]  EX_MEMREAD_i,
  input  logic [1:0]  EX_MEMWRITE_i,
  input  logic        EX_DMSE_i,
  output logic        STALL_o,
  output logic        M_VALID_o,
  output logic [31:0] M_RDATA_o,
  output logic        M_FAULT_o,
  dmem_access_unit_if.master dm
);

  localparam int AW = $clog2(DMEM_SIZE);
  // Counter is wide enough to reach TIMEOUT; one bit when the timeout is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);
  // First byte address past the memory, kept at 33 bits so it cannot wrap.
  localparam logic [32:0]   DMEM_END = {1'b0, DMEM_BASE} + 33'(DMEM_SIZE) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      ld_lo_q;
  logic [1:0]      ld_size_q;
  logic            ld_sign_q;
  logic            m_valid_q;
  logic [31:0]     m_rdata_q;
  logic            m_fault_q;
  logic            dm_req_q;
  logic            dm_we_q;
  logic [AW-1:0]   dm_addr_q;
  logic [3:0]      dm_be_q;
  logic [31:0]     dm_wdata_q;

  logic            ex_op;
  logic            ex_bad;
  logic [1:0]      ex_size;
  logic [32:0]     ex_last;
  logic [31:0]     ex_off;
  logic [3:0]      ex_be;
  logic [31:0]     ex_wdata;
  logic [31:0]     ld_shift;
  logic [31:0]     ld_data;
  logic            to_hit;

  // Decode the EX/MEM slot: op detection, fault check, lane enables and data.
  always_comb begin
    ex_op    = EX_VALID_i & ((EX_MEMREAD_i != 2'b00) | (EX_MEMWRITE_i != 2'b00));
    // Only one of the two fields is nonzero for a legal op, so OR yields the size.
    ex_size  = EX_MEMREAD_i | EX_MEMWRITE_i;
    ex_off   = EX_ADDR_i - DMEM_BASE;
    ex_last  = {1'b0, EX_ADDR_i};
    ex_be    = 4'b1111;
    ex_wdata = EX_WDATA_i;
    case (ex_size)
      2'b01: begin
        ex_be    = 4'b0001 << EX_ADDR_i[1:0];
        ex_wdata = {4{EX_WDATA_i[7:0]}};
      end
      2'b10: begin
        ex_last  = {1'b0, EX_ADDR_i} + 33'd1;
        ex_be    = 4'b0011 << EX_ADDR_i[1:0];
        ex_wdata = {2{EX_WDATA_i[15:0]}};
      end
      2'b11: begin
        ex_last  = {1'b0, EX_ADDR_i} + 33'd3;
      end
      default: begin
      end
    endcase
    ex_bad = ((EX_MEMREAD_i != 2'b00) & (EX_MEMWRITE_i != 2'b00))
           | ((ex_size == 2'b10) & EX_ADDR_i[0])
           | ((ex_size == 2'b11) & (EX_ADDR_i[1:0] != 2'b00))
           | (EX_ADDR_i < DMEM_BASE)
           | (ex_last >= DMEM_END);
  end

  // Align the returned word to the accessed lane and extend it to 32 bits.
  always_comb begin
    ld_shift = dm.DM_RDATA >> {ld_lo_q, 3'b000};
    case (ld_size_q)
      2'b01:   ld_data = {{24{ld_sign_q & ld_shift[7]}},  ld_shift[7:0]};
      2'b10:   ld_data = {{16{ld_sign_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = dm.DM_RDATA;
    endcase
  end

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LIM);

  // The stall must cover the accepting cycle, so it is decoded from the live
  // slot; it is forced low while reset is held.
  assign STALL_o = ~RST & ((state_q == S_REQ) | (state_q == S_WAIT) |
                           ((state_q == S_IDLE) & ex_op));

  assign M_VALID_o   = m_valid_q;
  assign M_RDATA_o   = m_rdata_q;
  assign M_FAULT_o   = m_fault_q;
  assign dm.DM_REQ   = dm_req_q;
  assign dm.DM_WE    = dm_we_q;
  assign dm.DM_ADDR  = dm_addr_q;
  assign dm.DM_BE    = dm_be_q;
  assign dm.DM_WDATA = dm_wdata_q;

  // Access sequencer with registered memory-port and result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ld_lo_q    <= 2'b00;
      ld_size_q  <= 2'b00;
      ld_sign_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_rdata_q  <= 32'h0;
      m_fault_q  <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= 4'b0000;
      dm_wdata_q <= 32'h0;
    end else begin
      m_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ex_op) begin
            ld_lo_q   <= EX_ADDR_i[1:0];
            ld_size_q <= ex_size;
            ld_sign_q <= EX_DMSE_i;
            if (ex_bad) begin
              state_q   <= S_DONE;
              m_valid_q <= 1'b1;
              m_fault_q <= 1'b1;
              m_rdata_q <= 32'h0;
            end else begin
              state_q    <= S_REQ;
              cnt_q      <= '0;
              dm_req_q   <= 1'b1;
              dm_we_q    <= (EX_MEMWRITE_i != 2'b00);
              dm_addr_q  <= ex_off[AW+1:2];
              dm_be_q    <= ex_be;
              dm_wdata_q <= ex_wdata;
            end
          end
        end
        S_REQ: begin
          if (dm.DM_GNT) begin
            dm_req_q <= 1'b0;
            cnt_q    <= '0;
            if (dm_we_q) begin
              state_q   <= S_DONE;
              m_valid_q <= 1'b1;
              m_fault_q <= 1'b0;
              m_rdata_q <= 32'h0;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (to_hit) begin
            dm_req_q  <= 1'b0;
            state_q   <= S_DONE;
            m_valid_q <= 1'b1;
            m_fault_q <= 1'b1;
            m_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (dm.DM_RVALID) begin
            state_q   <= S_DONE;
            m_valid_q <= 1'b1;
            m_fault_q <= 1'b0;
            m_rdata_q <= ld_data;
          end else if (to_hit) begin
            state_q   <= S_DONE;
            m_valid_q <= 1'b1;
            m_fault_q <= 1'b1;
            m_rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_dmem_access_unit
// Brief   : Self-checking bench for dmem_access_unit. A transaction-level
//           model predicts, per op, the stall window, request window, done
//           cycle and result. The bench acts as both the pipeline and the
//           memory, so every input is known to the model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          SIZE = 32768;
  localparam int          TO   = 12;
  localparam int          AW   = $clog2(SIZE);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EX_VALID_i = 1'b0;
  logic [31:0] EX_ADDR_i = 32'h0;
  logic [31:0] EX_WDATA_i = 32'h0;
  logic [1:0]  EX_MEMREAD_i = 2'b00;
  logic [1:0]  EX_MEMWRITE_i = 2'b00;
  logic        EX_DMSE_i = 1'b0;
  logic        STALL_o, M_VALID_o, M_FAULT_o;
  logic [31:0] M_RDATA_o;

  dmem_access_unit_if #(.AW(AW)) dm ();

  dmem_access_unit #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .EX_VALID_i(EX_VALID_i), .EX_ADDR_i(EX_ADDR_i), .EX_WDATA_i(EX_WDATA_i),
    .EX_MEMREAD_i(EX_MEMREAD_i), .EX_MEMWRITE_i(EX_MEMWRITE_i), .EX_DMSE_i(EX_DMSE_i),
    .STALL_o(STALL_o), .M_VALID_o(M_VALID_o), .M_RDATA_o(M_RDATA_o), .M_FAULT_o(M_FAULT_o),
    .dm(dm.master)
  );

  always #5 CLK = ~CLK;

  // One EX/MEM slot plus the memory behaviour the bench will apply to it.
  // g/r: cycles of delay before GNT/RVALID; -1 means the response never comes.
  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        sign;
    logic [31:0] rdata;
    int          g;
    int          r;
  } slot_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  slot_t ex, cur;
  slot_t forced_q[$];
  bit    advance = 1'b1;
  bit    random_mode = 1'b0;
  bit    late_rvalid = 1'b0;
  bit    busy = 1'b0;
  bit    op_done = 1'b0;
  bit    cur_good, cur_store;
  int    acc, req_len, wait_len, done_rel;
  logic [31:0] held_rdata = 32'h0;
  logic        held_fault = 1'b0;
  int    stall_cnt, mv_rel;
  bit    req_seen;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic slot_t mk(input logic [31:0] addr, input logic [1:0] rd, input logic [1:0] wr,
                               input logic sign, input logic [31:0] wdata, input logic [31:0] rdata,
                               input int g, input int r);
    slot_t s;
    s.valid = 1'b1; s.addr = addr; s.rd = rd; s.wr = wr; s.sign = sign;
    s.wdata = wdata; s.rdata = rdata; s.g = g; s.r = r;
    return s;
  endfunction

  function automatic slot_t idle_slot();
    slot_t s;
    s = mk($urandom, 2'b00, 2'b00, 1'b0, $urandom, $urandom, 0, 0);
    s.valid = 1'b0;
    return s;
  endfunction

  function automatic bit is_op(input slot_t s);
    return s.valid && (s.rd != 2'b00 || s.wr != 2'b00);
  endfunction

  function automatic int nbytes(input slot_t s);
    logic [1:0] sz;
    sz = (s.rd != 2'b00) ? s.rd : s.wr;
    return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic bit pre_fault(input slot_t s);
    longint a, lim;
    int n;
    a = s.addr; n = nbytes(s);
    lim = longint'(BASE) + 4 * longint'(SIZE);
    if (s.rd != 2'b00 && s.wr != 2'b00) return 1'b1;
    if (n == 2 && a % 2 != 0) return 1'b1;
    if (n == 4 && a % 4 != 0) return 1'b1;
    if (a < longint'(BASE)) return 1'b1;
    if (a + n - 1 >= lim) return 1'b1;
    return 1'b0;
  endfunction

  // Load result from the rules: pick the addressed lane(s), then extend.
  function automatic logic [31:0] load_val(input slot_t s);
    longint x, v;
    int lo, n;
    lo = int'(s.addr % 4); n = nbytes(s);
    x = longint'(s.rdata) / (longint'(1) << (8 * lo));
    if (n == 4) return s.rdata;
    if (n == 1) begin
      v = x % 256;
      if (s.sign && v >= 128) v = v - 256;
    end else begin
      v = x % 65536;
      if (s.sign && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_be(input slot_t s);
    int lo, n;
    lo = int'(s.addr % 4); n = nbytes(s);
    if (n == 1) return 4'(1 << lo);
    if (n == 2) return 4'(3 << lo);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input slot_t s);
    logic [31:0] b, h;
    int n;
    n = nbytes(s);
    b = s.wdata % 256;
    h = s.wdata % 65536;
    if (n == 1) return b * 32'h0101_0101;
    if (n == 2) return h * 32'h0001_0001;
    return s.wdata;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    int k, n;
    s = idle_slot();
    s.valid = ($urandom_range(0, 9) != 0);
    s.sign  = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 9);
    if (k < 4)       s.rd = 2'($urandom_range(1, 3));
    else if (k < 8)  s.wr = 2'($urandom_range(1, 3));
    else if (k == 8) begin s.rd = 2'($urandom_range(1, 3)); s.wr = 2'($urandom_range(1, 3)); end
    n = nbytes(s);
    k = $urandom_range(0, 9);
    if (k < 6)       s.addr = BASE + 32'($urandom_range(0, 4 * SIZE - 1));
    else if (k == 6) s.addr = BASE + 32'(4 * SIZE) - 32'($urandom_range(0, 4));
    else if (k == 7) s.addr = BASE - 32'($urandom_range(1, 4));
    else if (k == 8) s.addr = $urandom;
    else             s.addr = BASE + 32'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) s.addr = s.addr - (s.addr % 32'(n));
    k = $urandom_range(0, 9);
    s.g = (k < 6) ? 0 : (k < 9) ? $urandom_range(1, TO - 1) : -1;
    k = $urandom_range(0, 9);
    s.r = (k < 6) ? 0 : (k < 9) ? $urandom_range(1, TO - 1) : -1;
    return s;
  endfunction

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step();
    int rel;
    bit in_req, in_wait, e_stall, e_mv;
    if (advance) begin
      if (forced_q.size() != 0) ex = forced_q.pop_front();
      else if (random_mode)     ex = rand_slot();
      else                      ex = idle_slot();
    end
    if (!busy && is_op(ex)) begin
      busy = 1'b1; acc = cyc; cur = ex;
      cur_good  = !pre_fault(ex);
      cur_store = (ex.wr != 2'b00);
      req_len   = (ex.g < 0) ? TO + 1 : ex.g + 1;
      wait_len  = (ex.r < 0) ? TO + 1 : ex.r + 1;
      if (!cur_good)                  done_rel = 1;
      else if (cur_store || ex.g < 0) done_rel = 1 + req_len;
      else                            done_rel = 1 + req_len + wait_len;
      stall_cnt = 0; req_seen = 1'b0; mv_rel = -1;
    end
    rel     = busy ? cyc - acc : -1;
    e_stall = busy && rel < done_rel;
    e_mv    = busy && rel == done_rel;
    in_req  = busy && cur_good && rel >= 1 && rel <= req_len;
    in_wait = busy && cur_good && !cur_store && cur.g >= 0 && rel > req_len && rel < done_rel;

    EX_VALID_i    = ex.valid;
    EX_ADDR_i     = ex.addr;
    EX_WDATA_i    = ex.wdata;
    EX_MEMREAD_i  = ex.rd;
    EX_MEMWRITE_i = ex.wr;
    EX_DMSE_i     = ex.sign;
    // Outside their windows GNT/RVALID are randomly asserted to show they are ignored.
    dm.DM_GNT    = in_req  ? (cur.g >= 0 && rel == 1 + cur.g)
                           : ($urandom_range(0, 3) == 0);
    dm.DM_RVALID = in_wait ? (cur.r >= 0 && rel == done_rel - 1)
                           : ($urandom_range(0, 3) == 0);
    if (late_rvalid) begin dm.DM_RVALID = 1'b1; late_rvalid = 1'b0; end
    dm.DM_RDATA  = (in_wait && dm.DM_RVALID) ? cur.rdata : $urandom;

    @(negedge CLK);
    if (e_mv) begin
      held_fault = !cur_good || cur.g < 0 || (!cur_store && cur.r < 0);
      held_rdata = (held_fault || cur_store) ? 32'h0 : load_val(cur);
    end
    chk("stall", STALL_o, e_stall);
    chk("m_valid", M_VALID_o, e_mv);
    chk("dm_req", dm.DM_REQ, in_req);
    chk("m_rdata", M_RDATA_o, held_rdata);
    chk("m_fault", M_FAULT_o, held_fault);
    if (in_req) begin
      chk("dm_addr", 32'(dm.DM_ADDR), (cur.addr - BASE) / 4);
      chk("dm_be", dm.DM_BE, exp_be(cur));
      chk("dm_we", dm.DM_WE, cur_store);
      chk("dm_wdata", dm.DM_WDATA, cur_store ? exp_wdata(cur) : dm.DM_WDATA);
    end
    if (busy) begin
      if (STALL_o) stall_cnt++;
      if (dm.DM_REQ) begin
        req_seen = 1'b1; last_be = dm.DM_BE; last_wdata = dm.DM_WDATA; last_we = dm.DM_WE;
      end
      if (M_VALID_o && mv_rel < 0) mv_rel = rel;
    end
    if (e_mv) begin busy = 1'b0; op_done = 1'b1; end
    advance = !e_stall;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_forced(input slot_t s);
    int guard;
    guard = 0;
    forced_q.push_back(s);
    op_done = 1'b0;
    while (!op_done && guard < 200) begin
      step();
      guard++;
    end
    if (!op_done) begin
      vectors++; miscompares++;
      $display("FAIL op_bound: op did not complete within %0d cycles", guard);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, STALL_o, 0);
    chk({tag, "_m_valid"}, M_VALID_o, 0);
    chk({tag, "_m_rdata"}, M_RDATA_o, 0);
    chk({tag, "_m_fault"}, M_FAULT_o, 0);
    chk({tag, "_dm_req"}, dm.DM_REQ, 0);
    chk({tag, "_dm_we"}, dm.DM_WE, 0);
    chk({tag, "_dm_addr"}, 32'(dm.DM_ADDR), 0);
    chk({tag, "_dm_be"}, dm.DM_BE, 0);
    chk({tag, "_dm_wdata"}, dm.DM_WDATA, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dm.DM_GNT = 1'b0; dm.DM_RVALID = 1'b0; dm.DM_RDATA = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    step();

    // sb 0xA5 at BASE+3, immediate grant.
    run_forced(mk(BASE + 3, 2'b00, 2'b01, 1'b0, 32'h0000_00A5, 32'h0, 0, 0));
    chk("sb_be", last_be, 4'b1000);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    chk("sb_we", last_we, 1'b1);
    chk("sb_mv_cycle", mv_rel, 2);
    chk("sb_stall_cycles", stall_cnt, 2);

    // lb / lbu at BASE+1.
    run_forced(mk(BASE + 1, 2'b01, 2'b00, 1'b1, 32'h0, 32'h0000_8000, 0, 0));
    chk("lb_rdata", M_RDATA_o, 32'hFFFF_FF80);
    chk("lb_mv_cycle", mv_rel, 3);
    run_forced(mk(BASE + 1, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0000_8000, 0, 0));
    chk("lbu_rdata", M_RDATA_o, 32'h0000_0080);

    // lhu at BASE+2.
    run_forced(mk(BASE + 2, 2'b10, 2'b00, 1'b0, 32'h0, 32'h8001_1234, 0, 0));
    chk("lh_be", last_be, 4'b1100);
    chk("lh_rdata", M_RDATA_o, 32'h0000_8001);

    // Misaligned and out-of-range words never reach the memory port.
    run_forced(mk(BASE + 2, 2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 0, 0));
    chk("lw_mis_req", req_seen, 1'b0);
    chk("lw_mis_fault", M_FAULT_o, 1'b1);
    run_forced(mk(BASE + 32'(4 * SIZE), 2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 0, 0));
    chk("lw_oor_req", req_seen, 1'b0);
    chk("lw_oor_fault", M_FAULT_o, 1'b1);

    // Slow memory: grant after 5 cycles, data 3 cycles later.
    run_forced(mk(BASE + 8, 2'b11, 2'b00, 1'b0, 32'h0, 32'hCAFE_F00D, 5, 3));
    chk("slow_rdata", M_RDATA_o, 32'hCAFE_F00D);
    chk("slow_stall_cycles", stall_cnt, 11);

    // No grant ever: the request times out.
    run_forced(mk(BASE, 2'b00, 2'b11, 1'b0, 32'h1234_5678, 32'h0, -1, 0));
    chk("to_fault", M_FAULT_o, 1'b1);
    chk("to_mv_cycle", mv_rel, TO + 2);

    // Reset while waiting for read data, then a late RVALID.
    forced_q.push_back(mk(BASE + 12, 2'b11, 2'b00, 1'b0, 32'h0, 32'h5555_AAAA, 0, -1));
    repeat (3) step();
    RST = 1'b1;
    #2;
    chk_all_zero("rst_wait");
    EX_VALID_i = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    busy = 1'b0; held_rdata = 32'h0; held_fault = 1'b0;
    ex = idle_slot(); advance = 1'b1; late_rvalid = 1'b1;
    @(posedge CLK);
    #1;
    repeat (3) step();

    random_mode = 1'b1;
    repeat (4000) step();
    random_mode = 1'b0;
    repeat (TO + 20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
